mem_stage: RTL and testbench

- MEM pipeline stage of the 5-stage CPU.
- Consumes the EX/MEM register, performs word load/store to the internal SPM (1 cycle) or the external bus (request/grant/ready handshake), and detects misalignment.
- Produces the registered mem_* bundle consumed by the CPU control unit and the register file writeback.
- Generates mem_busy, which stalls the whole pipeline during bus transactions.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_bus_if.sv | 101 ++++++++++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: memory ops, exception codes,
// bus FSM states and datapath widths.
package mem_stage_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_OP_NOP = 2'd0,
    MEM_OP_LDW = 2'd1,
    MEM_OP_STW = 2'd2
  } mem_op_t;

  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [2:0] ISA_EXP_PRV_VIO    = 3'd6;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_REQ    = 2'd1,
    BUS_ACCESS = 2'd2,
    BUS_STALL  = 2'd3
  } bus_state_t;

endpackage

// File: rtl/mem_stage_bus_if.sv
// External bus master for the MEM stage: request/grant/ready handshake
// FSM plus the read-data latch that survives a pipeline stall.
module mem_stage_bus_if
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   start,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   rw,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic                   busy,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_
);

  bus_state_t             state_reg, state_next;
  logic [WORD_ADDR_W-1:0] addr_reg;
  logic                   rw_reg;
  logic [WORD_DATA_W-1:0] wr_data_reg;
  logic [WORD_DATA_W-1:0] rd_data_reg;

  // Request parameters are captured at start so a flush upstream cannot
  // corrupt a transaction already on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= BUS_IDLE;
      addr_reg    <= '0;
      rw_reg      <= 1'b0;
      wr_data_reg <= '0;
      rd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == BUS_IDLE && start) begin
        addr_reg    <= addr;
        rw_reg      <= rw;
        wr_data_reg <= wr_data;
      end
      if (state_reg == BUS_ACCESS && !bus_rdy_) begin
        rd_data_reg <= bus_rd_data;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    bus_req_    = 1'b1;
    bus_as_     = 1'b1;
    bus_addr    = '0;
    bus_rw      = 1'b0;
    bus_wr_data = '0;
    case (state_reg)
      BUS_IDLE: begin
        if (start) begin
          bus_req_   = 1'b0;
          busy       = 1'b1;
          state_next = BUS_REQ;
        end
      end
      BUS_REQ: begin
        bus_req_ = 1'b0;
        busy     = 1'b1;
        if (!bus_grnt_) begin
          bus_as_     = 1'b0;
          bus_addr    = addr_reg;
          bus_rw      = rw_reg;
          bus_wr_data = wr_data_reg;
          state_next  = BUS_ACCESS;
        end
      end
      BUS_ACCESS: begin
        bus_req_ = 1'b0;
        busy     = 1'b1;
        if (!bus_rdy_) begin
          bus_req_   = 1'b1;
          busy       = 1'b0;
          state_next = stall ? BUS_STALL : BUS_IDLE;
        end
      end
      BUS_STALL: begin
        if (!stall) begin
          state_next = BUS_IDLE;
        end
      end
      default: state_next = BUS_IDLE;
    endcase
  end

  // In the ready cycle the result is forwarded straight from the bus.
  assign rd_data = (state_reg == BUS_ACCESS) ? bus_rd_data : rd_data_reg;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: word load/store to the scratch-pad memory or the
// external bus, misalignment detection and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] SPM_BASE       = 30'h0,
  parameter int                     SPM_DEPTH_LOG2 = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      busy,
  input  logic [29:0]               ex_pc,
  input  logic                      ex_en,
  input  logic                      ex_br_flag,
  input  logic [1:0]                ex_mem_op,
  input  logic [31:0]               ex_mem_wr_data,
  input  logic [1:0]                ex_ctrl_op,
  input  logic [4:0]                ex_dst_addr,
  input  logic                      ex_gpr_we_,
  input  logic [2:0]                ex_exp_code,
  input  logic [31:0]               ex_out,
  output logic [SPM_DEPTH_LOG2-1:0] spm_addr,
  output logic                      spm_as_,
  output logic                      spm_rw,
  output logic [31:0]               spm_wr_data,
  input  logic [31:0]               spm_rd_data,
  output logic                      bus_req_,
  input  logic                      bus_grnt_,
  output logic [29:0]               bus_addr,
  output logic                      bus_as_,
  output logic                      bus_rw,
  output logic [31:0]               bus_wr_data,
  input  logic [31:0]               bus_rd_data,
  input  logic                      bus_rdy_,
  output logic [29:0]               mem_pc,
  output logic                      mem_en,
  output logic                      mem_br_flag,
  output logic [1:0]                mem_ctrl_op,
  output logic [4:0]                mem_dst_addr,
  output logic                      mem_gpr_we_,
  output logic [2:0]                mem_exp_code,
  output logic [31:0]               mem_out
);

  logic                   valid, is_ld, is_st, miss_align, access;
  logic                   spm_hit, bus_start, fsm_busy;
  logic                   update, bubble;
  logic                   flush_pend_reg;
  logic [WORD_ADDR_W-1:0] word_addr, spm_off;
  logic [WORD_DATA_W-1:0] bus_ld_data, ld_data;

  assign valid      = ex_en && (ex_exp_code == ISA_EXP_NO_EXP);
  assign is_ld      = (ex_mem_op == MEM_OP_LDW);
  assign is_st      = (ex_mem_op == MEM_OP_STW);
  assign miss_align = valid && (is_ld || is_st) && (ex_out[1:0] != 2'b00);
  assign access     = valid && (is_ld || is_st) && !miss_align;

  assign word_addr = ex_out[31:2];
  assign spm_off   = word_addr - SPM_BASE;
  assign spm_hit   = (word_addr >= SPM_BASE) && ((spm_off >> SPM_DEPTH_LOG2) == '0);

  // The SPM strobe is withheld while stalled so a store fires exactly once,
  // in the cycle the instruction actually leaves the stage.
  assign spm_addr    = spm_off[SPM_DEPTH_LOG2-1:0];
  assign spm_as_     = !(access && spm_hit && !stall && !flush && !reset);
  assign spm_rw      = !is_st;
  assign spm_wr_data = ex_mem_wr_data;

  assign bus_start = access && !spm_hit && !flush && !reset;

  mem_stage_bus_if u_bus_if (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .start       (bus_start),
    .addr        (word_addr),
    .rw          (is_ld),
    .wr_data     (ex_mem_wr_data),
    .busy        (fsm_busy),
    .rd_data     (bus_ld_data),
    .bus_req_    (bus_req_),
    .bus_grnt_   (bus_grnt_),
    .bus_addr    (bus_addr),
    .bus_as_     (bus_as_),
    .bus_rw      (bus_rw),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy_    (bus_rdy_)
  );

  assign busy    = fsm_busy;
  assign ld_data = spm_hit ? spm_rd_data : bus_ld_data;
  assign update  = !fsm_busy && !stall;
  assign bubble  = flush || flush_pend_reg || !ex_en;

  // A flush seen while the bus is busy is remembered so the finished
  // transaction's result is discarded instead of written back.
  always_ff @(posedge clk) begin
    if (reset || update) begin
      flush_pend_reg <= 1'b0;
    end else if (flush && fsm_busy) begin
      flush_pend_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (update && bubble)) begin
      mem_pc       <= '0;
      mem_en       <= 1'b0;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= 2'd0;
      mem_dst_addr <= '0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= ISA_EXP_NO_EXP;
      mem_out      <= '0;
    end else if (update) begin
      mem_pc       <= ex_pc;
      mem_en       <= ex_en;
      mem_br_flag  <= ex_br_flag;
      mem_ctrl_op  <= ex_ctrl_op;
      mem_dst_addr <= ex_dst_addr;
      mem_gpr_we_  <= miss_align ? 1'b1 : ex_gpr_we_;
      mem_exp_code <= (ex_exp_code != ISA_EXP_NO_EXP) ? ex_exp_code :
                      (miss_align ? ISA_EXP_MISS_ALIGN : ISA_EXP_NO_EXP);
      mem_out      <= (is_ld && access) ? ld_data : ex_out;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle cases plus
// hand sequences for bus handshakes, stall, flush and reset.
module tb_mem_stage;

  logic        clk, reset, stall, flush, busy;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic [11:0] spm_addr;
  logic        spm_as_, spm_rw;
  logic [31:0] spm_wr_data, spm_rd_data;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus slave model: grant after grant_wait request cycles, ready after
  // rdy_wait access cycles following the address strobe.
  int   grant_wait, rdy_wait, req_seen, acc_seen;
  logic granted;

  always @(posedge clk) begin
    if (reset) begin
      req_seen <= 0; acc_seen <= 0; granted <= 1'b0;
    end else if (!bus_as_) begin
      granted <= 1'b1; acc_seen <= 0; req_seen <= 0;
    end else if (granted) begin
      if (!bus_rdy_) granted <= 1'b0;
      else acc_seen <= acc_seen + 1;
    end else if (!bus_req_) begin
      req_seen <= req_seen + 1;
    end else begin
      req_seen <= 0;
    end
  end

  assign bus_grnt_ = !(!granted && !bus_req_ && (req_seen >= grant_wait));
  assign bus_rdy_  = !(granted && (acc_seen >= rdy_wait));

  typedef struct {
    logic        en;  logic [1:0] op; logic [2:0] exp; logic [31:0] out;
    logic [31:0] wd;  logic we_;      logic [31:0] rd;
    logic        x_as_; logic [11:0] x_addr; logic x_en; logic [31:0] x_out;
    logic [2:0]  x_exp; logic x_we_;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    ex_en = 0; ex_mem_op = 0; ex_exp_code = 0; ex_out = 0; ex_mem_wr_data = 0;
    ex_gpr_we_ = 1; ex_pc = 0; ex_br_flag = 0; ex_ctrl_op = 0; ex_dst_addr = 0;
    stall = 0; flush = 0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] out,
                       input logic [31:0] wd, input logic we_);
    ex_en = 1; ex_mem_op = op; ex_exp_code = 0; ex_out = out;
    ex_mem_wr_data = wd; ex_gpr_we_ = we_;
  endtask

  // Runs the current bus access until busy drops; flush is pulsed in
  // cycle flush_at (counted from the request cycle).
  task automatic run_bus(input int flush_at, output int busy_cnt, output int as_cnt,
                         output logic [29:0] a, output logic r, output logic [31:0] d);
    bit done;
    done = 0; busy_cnt = 0; as_cnt = 0; a = '0; r = 0; d = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      flush = (c == flush_at);
      #1;
      if (!bus_as_) begin
        as_cnt++; a = bus_addr; r = bus_rw; d = bus_wr_data;
      end
      if (!busy) done = 1;
      else begin
        busy_cnt++;
        tick();
      end
    end
    flush = 0;
    chk("bus_done", {31'd0, done}, 32'd1);
  endtask

  int          bcnt, acnt;
  logic [29:0] baddr;
  logic        brw;
  logic [31:0] bwd;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       en op exp out            wd            we rd           | as addr    en out            exp we
    vecs[0] = '{1, 1, 0, 32'h40,       32'h0,        0, 32'hDEADBEEF, 0, 12'h010, 1, 32'hDEADBEEF, 0, 0};
    vecs[1] = '{1, 2, 0, 32'h80,       32'h12345678, 1, 32'h0,        0, 12'h020, 1, 32'h00000080, 0, 1};
    vecs[2] = '{1, 1, 0, 32'h102,      32'h0,        0, 32'hAAAA5555, 1, 12'h040, 1, 32'h00000102, 4, 1};
    vecs[3] = '{1, 1, 2, 32'h40,       32'h0,        0, 32'hAAAA5555, 1, 12'h010, 1, 32'h00000040, 2, 0};
    vecs[4] = '{0, 1, 0, 32'h40,       32'h0,        0, 32'hAAAA5555, 1, 12'h010, 0, 32'h00000000, 0, 1};
    vecs[5] = '{1, 1, 0, 32'h3FFC,     32'h0,        0, 32'hCAFEF00D, 0, 12'hFFF, 1, 32'hCAFEF00D, 0, 0};
    vecs[6] = '{1, 0, 0, 32'h12345679, 32'h0,        1, 32'hAAAA5555, 1, 12'h59E, 1, 32'h12345679, 0, 1};
    vecs[7] = '{1, 2, 0, 32'h40000001, 32'h55,       1, 32'hAAAA5555, 1, 12'h000, 1, 32'h40000001, 4, 1};

    reset = 1; idle_inputs(); grant_wait = 1; rdy_wait = 0;
    bus_rd_data = 0; spm_rd_data = 0;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_mem_en", {31'd0, mem_en}, 32'd1 - 32'd1);
    chk("rst_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
    chk("rst_exp", {29'd0, mem_exp_code}, 32'd0);
    chk("rst_out", mem_out, 32'd0);
    chk("rst_bus_req_", {31'd0, bus_req_}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    $display("txn reset");

    for (int i = 0; i < 8; i++) begin
      ex_en = vecs[i].en; ex_mem_op = vecs[i].op; ex_exp_code = vecs[i].exp;
      ex_out = vecs[i].out; ex_mem_wr_data = vecs[i].wd; ex_gpr_we_ = vecs[i].we_;
      ex_pc = 30'h100 + 30'(i); ex_dst_addr = 5'(i + 1); ex_ctrl_op = 2'd3;
      spm_rd_data = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_spm_as_", i), {31'd0, spm_as_}, {31'd0, vecs[i].x_as_});
      chk($sformatf("v%0d_spm_addr", i), {20'd0, spm_addr}, {20'd0, vecs[i].x_addr});
      chk($sformatf("v%0d_bus_req_", i), {31'd0, bus_req_}, 32'd1);
      tick();
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].x_en});
      chk($sformatf("v%0d_mem_out", i), mem_out, vecs[i].x_out);
      chk($sformatf("v%0d_mem_exp", i), {29'd0, mem_exp_code}, {29'd0, vecs[i].x_exp});
      chk($sformatf("v%0d_mem_we_", i), {31'd0, mem_gpr_we_}, {31'd0, vecs[i].x_we_});
      chk($sformatf("v%0d_mem_pc", i), {2'd0, mem_pc}, vecs[i].x_en ? 32'h100 + i : 32'd0);
      chk($sformatf("v%0d_mem_dst", i), {27'd0, mem_dst_addr}, vecs[i].x_en ? 32'(i + 1) : 32'd0);
      chk($sformatf("v%0d_mem_ctrl", i), {30'd0, mem_ctrl_op}, vecs[i].x_en ? 32'd3 : 32'd0);
      $display("txn vec %0d op=%0d addr=%h mem_out=%h", i, vecs[i].op, vecs[i].out, mem_out);
    end
    idle_inputs(); tick();

    // SPM store held off while stalled, fires once stall drops
    drive(2'd2, 32'h80, 32'hA5A5A5A5, 1'b1); stall = 1;
    #1; chk("stall_spm_as_", {31'd0, spm_as_}, 32'd1);
    tick(); stall = 0;
    #1;
    chk("spm_st_as_", {31'd0, spm_as_}, 32'd0);
    chk("spm_st_rw", {31'd0, spm_rw}, 32'd0);
    chk("spm_st_wd", spm_wr_data, 32'hA5A5A5A5);
    tick(); idle_inputs();
    chk("spm_st_mem_out", mem_out, 32'h80);
    $display("txn spm store under stall");
    tick();

    // Bus store: grant after 2, ready after 1 -> busy 4 cycles
    grant_wait = 2; rdy_wait = 1;
    drive(2'd2, 32'h40000000, 32'h12345678, 1'b1);
    run_bus(-1, bcnt, acnt, baddr, brw, bwd);
    chk("stw_busy_cnt", bcnt, 32'd4);
    chk("stw_as_cnt", acnt, 32'd1);
    chk("stw_addr", {2'd0, baddr}, 32'h10000000);
    chk("stw_rw", {31'd0, brw}, 32'd0);
    chk("stw_wd", bwd, 32'h12345678);
    tick(); idle_inputs();
    chk("stw_mem_out", mem_out, 32'h40000000);
    chk("stw_mem_en", {31'd0, mem_en}, 32'd1);
    #1; chk("stw_req_released", {31'd0, bus_req_}, 32'd1);
    $display("txn bus store busy=%0d", bcnt);
    tick();

    // First word past the SPM window goes to the bus, minimum latency
    grant_wait = 1; rdy_wait = 0; bus_rd_data = 32'h0BADF00D;
    drive(2'd1, 32'h4000, 32'h0, 1'b0);
    #1; chk("bnd_spm_as_", {31'd0, spm_as_}, 32'd1);
    run_bus(-1, bcnt, acnt, baddr, brw, bwd);
    chk("bnd_busy_cnt", bcnt, 32'd2);
    chk("bnd_addr", {2'd0, baddr}, 32'h1000);
    chk("bnd_rw", {31'd0, brw}, 32'd1);
    tick();
    chk("bnd_mem_out", mem_out, 32'h0BADF00D);
    chk("bnd_mem_we_", {31'd0, mem_gpr_we_}, 32'd0);
    $display("txn bus load boundary busy=%0d", bcnt);

    // Bus load with stall held across the ready cycle
    bus_rd_data = 32'h5A5A1234; stall = 1;
    drive(2'd1, 32'h80000000, 32'h0, 1'b0);
    run_bus(-1, bcnt, acnt, baddr, brw, bwd);
    chk("stl_busy_cnt", bcnt, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick(); bus_rd_data = 32'hFFFF0000;
      #1;
      chk($sformatf("stl%0d_bus_req_", k), {31'd0, bus_req_}, 32'd1);
      chk($sformatf("stl%0d_busy", k), {31'd0, busy}, 32'd0);
      chk($sformatf("stl%0d_mem_out_held", k), mem_out, 32'h0BADF00D);
    end
    stall = 0;
    tick();
    chk("stl_mem_out", mem_out, 32'h5A5A1234);
    $display("txn bus load under stall");

    // Flush during ACCESS: transaction finishes, result discarded
    grant_wait = 1; rdy_wait = 2; bus_rd_data = 32'h11112222;
    drive(2'd1, 32'h40000000, 32'h0, 1'b0);
    run_bus(2, bcnt, acnt, baddr, brw, bwd);
    chk("fl_busy_cnt", bcnt, 32'd4);
    chk("fl_as_cnt", acnt, 32'd1);
    tick(); idle_inputs();
    chk("fl_mem_en", {31'd0, mem_en}, 32'd0);
    chk("fl_mem_we_", {31'd0, mem_gpr_we_}, 32'd1);
    chk("fl_mem_out", mem_out, 32'd0);
    $display("txn bus load flushed");

    // No new bus request while flush is high
    drive(2'd2, 32'h40000000, 32'h1, 1'b1); flush = 1;
    #1;
    chk("flreq_bus_req_", {31'd0, bus_req_}, 32'd1);
    chk("flreq_busy", {31'd0, busy}, 32'd0);
    tick(); idle_inputs();
    $display("txn request suppressed by flush");

    // Reset while the FSM waits in REQ
    drive(2'd1, 32'h40, 32'h0, 1'b0); spm_rd_data = 32'h77;
    tick();
    grant_wait = 10;
    drive(2'd2, 32'h40000000, 32'h9, 1'b1);
    #1;
    chk("rreq_mem_out", mem_out, 32'h77);
    chk("rreq_idle_req_", {31'd0, bus_req_}, 32'd0);
    tick();
    chk("rreq_busy", {31'd0, busy}, 32'd1);
    chk("rreq_req_", {31'd0, bus_req_}, 32'd0);
    reset = 1; idle_inputs();
    tick();
    reset = 0;
    #1;
    chk("rreq_after_req_", {31'd0, bus_req_}, 32'd1);
    chk("rreq_after_as_", {31'd0, bus_as_}, 32'd1);
    chk("rreq_after_busy", {31'd0, busy}, 32'd0);
    chk("rreq_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rreq_mem_we_", {31'd0, mem_gpr_we_}, 32'd1);
    chk("rreq_mem_out0", mem_out, 32'd0);
    chk("rreq_mem_exp", {29'd0, mem_exp_code}, 32'd0);
    $display("txn reset during request");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
